// File: rtl/key_entry_16bit.sv
// Front-panel key entry: debounces three active-low buttons, assembles a 4-digit
// hex operand from SW[3:0] and hands it to the CPU over a valid/ready handshake.
module key_entry_16bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key_n,
  input  logic [3:0]  sw,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ENTRY, HOLD} state_t;

  logic [2:0]       key_sync_p0, key_sync_p1;
  logic [2:0]       key_stable, key_stable_nxt, key_evt;
  logic [CNT_W-1:0] db_cnt [3];
  logic [CNT_W-1:0] db_cnt_nxt [3];

  state_t      state, state_nxt;
  logic [15:0] entry_nxt, dout_nxt;
  logic [2:0]  count_nxt;
  logic        valid_nxt;
  logic        shift_evt, clear_evt, commit_evt;

  // Debounce: a level change is accepted only after CNT_MAX+1 consecutive differing samples
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      key_stable_nxt[k] = key_stable[k];
      db_cnt_nxt[k]     = '0;
      if (key_sync_p1[k] != key_stable[k]) begin
        if (db_cnt[k] == CNT_MAX) key_stable_nxt[k] = key_sync_p1[k];
        else                      db_cnt_nxt[k]     = db_cnt[k] + 1'b1;
      end
    end
  end

  // Stage p0/p1: two-flop synchroniser, then debounced level and press pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync_p0 <= 3'b111;
      key_sync_p1 <= 3'b111;
      key_stable  <= 3'b111;
      key_evt     <= 3'b000;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
      key_stable  <= key_stable_nxt;
      key_evt     <= key_stable & ~key_stable_nxt;
      for (int k = 0; k < 3; k++) db_cnt[k] <= db_cnt_nxt[k];
    end
  end

  assign shift_evt  = key_evt[0];
  assign clear_evt  = key_evt[1];
  assign commit_evt = key_evt[2];

  always_comb begin
    state_nxt = state;
    entry_nxt = entry_value;
    count_nxt = digit_count;
    dout_nxt  = data_out;
    valid_nxt = data_valid;
    case (state)
      ENTRY: begin
        if (clear_evt) begin
          entry_nxt = '0;
          count_nxt = '0;
        end else if (commit_evt) begin
          if (digit_count != 3'd0) begin
            dout_nxt  = entry_value;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end else if (shift_evt && digit_count < 3'd4) begin
          entry_nxt = {entry_value[11:0], sw};
          count_nxt = digit_count + 3'd1;
        end
      end
      HOLD: begin
        // Handover takes precedence; any key event in the accept cycle is dropped
        if (data_valid && data_ready) begin
          valid_nxt = 1'b0;
          entry_nxt = '0;
          count_nxt = '0;
          state_nxt = ENTRY;
        end else if (clear_evt) begin
          entry_nxt = '0;
          count_nxt = '0;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ENTRY;
      entry_value <= '0;
      digit_count <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      entry_value <= entry_nxt;
      digit_count <= count_nxt;
      data_out    <= dout_nxt;
      data_valid  <= valid_nxt;
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_key_entry_16bit.sv
// Directed bench for key_entry_16bit with a short debounce window.
module tb_key_entry_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  key_n;
  logic [3:0]  sw;
  logic [15:0] entry_value;
  logic [2:0]  digit_count;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  key_entry_16bit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .sw(sw),
    .entry_value(entry_value), .digit_count(digit_count),
    .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mask;   // active-high: [0]=shift [1]=clear [2]=commit
    logic [3:0]  sw;
    logic [15:0] e_val;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic [15:0] e_dout;
    logic        e_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ev, input logic [2:0] ec,
                         input logic vl, input logic [15:0] dv, input logic bz);
    chk({tag, ".entry_value"}, 32'(entry_value), 32'(ev));
    chk({tag, ".digit_count"}, 32'(digit_count), 32'(ec));
    chk({tag, ".data_valid"},  32'(data_valid),  32'(vl));
    chk({tag, ".data_out"},    32'(data_out),    32'(dv));
    chk({tag, ".busy"},        32'(busy),        32'(bz));
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] d, input int hold);
    sw    = d;
    key_n = ~mask;
    tick(hold);
    key_n = 3'b111;
    tick(12);
  endtask

  task automatic run_vec(input int i);
    press(vecs[i].mask, vecs[i].sw, 10);
    chk_all($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_cnt,
            vecs[i].e_vld, vecs[i].e_dout, vecs[i].e_busy);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 4'h0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{3'b001, 4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{3'b001, 4'h2, 16'h0012, 3'd2, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{3'b001, 4'h3, 16'h0123, 3'd3, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{3'b001, 4'h4, 16'h1234, 3'd4, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{3'b001, 4'hF, 16'h1234, 3'd4, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{3'b100, 4'h0, 16'h1234, 3'd4, 1'b1, 16'h1234, 1'b1};
    vecs[7]  = '{3'b001, 4'h7, 16'h1234, 3'd4, 1'b1, 16'h1234, 1'b1};
    vecs[8]  = '{3'b100, 4'h0, 16'h0000, 3'd0, 1'b0, 16'h1234, 1'b0};
    vecs[9]  = '{3'b001, 4'h5, 16'h0005, 3'd1, 1'b0, 16'h1234, 1'b0};
    vecs[10] = '{3'b110, 4'h0, 16'h0000, 3'd0, 1'b0, 16'h1234, 1'b0};
    vecs[11] = '{3'b001, 4'hA, 16'h000A, 3'd1, 1'b0, 16'h1234, 1'b0};
    vecs[12] = '{3'b001, 4'hB, 16'h00AB, 3'd2, 1'b0, 16'h1234, 1'b0};
    vecs[13] = '{3'b100, 4'h0, 16'h00AB, 3'd2, 1'b1, 16'h00AB, 1'b1};
    vecs[14] = '{3'b010, 4'h0, 16'h0000, 3'd0, 1'b1, 16'h00AB, 1'b1};
    vecs[15] = '{3'b001, 4'hC, 16'h0000, 3'd0, 1'b1, 16'h00AB, 1'b1};
    vecs[16] = '{3'b100, 4'h0, 16'h0000, 3'd0, 1'b1, 16'h00AB, 1'b1};

    rst = 1'b0; key_n = 3'b111; sw = 4'h0; data_ready = 1'b0;
    tick(2);
    chk_all("reset", 16'h0, 3'd0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    tick(100);
    chk_all("idle", 16'h0, 3'd0, 1'b0, 16'h0, 1'b0);

    // Short bounces on the shift key must not register
    sw = 4'hA;
    key_n = 3'b110; tick(3);
    key_n = 3'b111; tick(1);
    key_n = 3'b110; tick(3);
    key_n = 3'b111; tick(12);
    chk_all("bounce", 16'h0, 3'd0, 1'b0, 16'h0, 1'b0);
    press(3'b001, 4'hA, 10);
    chk_all("first_shift", 16'h000A, 3'd1, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i <= 7; i++) run_vec(i);

    // Operand held stable while the consumer is not ready
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk($sformatf("hold%0d.valid", c), 32'(data_valid), 32'd1);
      chk($sformatf("hold%0d.dout", c),  32'(data_out),   32'h1234);
    end
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    chk_all("accept", 16'h0, 3'd0, 1'b0, 16'h1234, 1'b0);
    tick(5);
    chk_all("post_accept", 16'h0, 3'd0, 1'b0, 16'h1234, 1'b0);

    for (int i = 8; i <= 16; i++) run_vec(i);

    // Asynchronous reset in HOLD, with shift already held down
    #2;
    rst = 1'b0;
    sw = 4'h9;
    key_n = 3'b110;
    #1;
    chk_all("async_rst", 16'h0, 3'd0, 1'b0, 16'h0, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(20);
    chk_all("held_after_rst", 16'h0009, 3'd1, 1'b0, 16'h0, 1'b0);
    key_n = 3'b111;
    tick(12);
    chk_all("single_evt", 16'h0009, 3'd1, 1'b0, 16'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_entry_16bit.md
Name: key_entry_16bit

Overview:
Front-panel input block: the input-side counterpart of the 16-bit hex display path. Debounces three active-low pushbuttons and builds a 4-digit hex value one nibble at a time from SW[3:0]. Exposes the in-progress value for live display on HEX0-HEX3. Hands a committed 16-bit operand to the CPU over a valid/ready handshake, replacing the fixed sign-extended switch input.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a key level change (1 ms at 50 MHz); legal range 2..2^20.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous active-low reset (driven from KEY[0])
key_n  input  3  raw active-low buttons: [0]=shift-digit (KEY[1]), [1]=clear (KEY[2]), [2]=commit (KEY[3])
sw  input  4  hex digit to shift in (SW[3:0])
entry_value  output  16  current entry buffer, for hex display
digit_count  output  3  digits entered, 0..4
data_out  output  16  committed operand
data_valid  output  1  operand available
data_ready  input  1  consumer accepts operand this cycle
busy  output  1  high while in HOLD

Behaviour:
- Reset (rst=0, async): entry_value=0, digit_count=0, data_out=0, data_valid=0, busy=0, state=ENTRY. Sync flops and debounced levels=1 (released). Debounce counters=0. Event pulses=0.
- Synchroniser: each key_n bit passes through 2 flops; debounce logic sees stage-2 output only.
- Debounce, per key: if synced==stable, counter<=0. Else, if counter==DEBOUNCE_CYCLES-1: stable<=synced, counter<=0; otherwise counter increments. A bounce shorter than DEBOUNCE_CYCLES never changes stable.
- Press event: registered 1-cycle pulse on stable 1->0. Releases generate no event. Holding a key generates exactly one event.
- Latency: key held low from cycle 0 -> sync stage 2 low at cycle 2 -> stable falls at edge 2+DEBOUNCE_CYCLES -> event pulse in the next cycle -> action visible on outputs one edge later.
- Priority for same-cycle events: clear > commit > shift.
- FSM state ENTRY:
  - clear event: entry_value<=0, digit_count<=0.
  - commit event with digit_count>0: data_out<=entry_value, data_valid<=1, busy<=1, go to HOLD.
  - commit event with digit_count==0: ignored.
  - shift event with digit_count<4: entry_value<={entry_value[11:0], sw}, digit_count+1.
  - shift event with digit_count==4: ignored. No wrap and no overwrite.
- FSM state HOLD:
  - data_valid and data_out held stable until accepted.
  - shift and commit events ignored.
  - clear event zeroes entry_value/digit_count only; data_valid and data_out are unaffected.
  - data_valid & data_ready at an edge: data_valid<=0, busy<=0, entry_value<=0, digit_count<=0, return to ENTRY. Events in that same cycle are dropped.
- data_ready is ignored while data_valid=0.
- Value is raw 16-bit. No sign extension; the consumer interprets it as two's complement.
- Reset asserted mid-debounce or in HOLD: immediate return to reset values. A key still held low after reset release must bounce-qualify again and then produces one event.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4.)
- Reset then idle -> all outputs 0, busy=0; key_n=3'b111 for 100 cycles produces no events.
- Bounce: shift key low 3 cycles, high 1, low 3, high -> entry_value=0, digit_count=0. Then low 10 cycles with sw=4'hA -> entry_value=16'h000A, digit_count=1, exactly one shift.
- Enter sw=1,2,3,4, then a 5th shift with sw=F -> entry_value=16'h1234, digit_count=4 after both the 4th and 5th shifts.
- Commit with data_ready=0 for 20 cycles -> data_valid=1, data_out=16'h1234, busy=1, held stable. Then data_ready=1 for one cycle -> next edge data_valid=0, entry_value=0, state ENTRY.
- Commit at digit_count=0 -> data_valid stays 0. Clear and commit debounced in the same cycle -> clear wins, no valid.
- In HOLD, press clear -> entry_value=0 while data_out=16'h1234 and data_valid=1 persist. Assert rst=0 mid-HOLD -> data_valid=0, data_out=0 asynchronously.
